// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the multicycle multiply unit: FSM encoding and
// the fixed iteration count of the shift-and-add loop.
package cpu_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    NEG_LO = 3'd2,
    NEG_HI = 3'd3,
    DONE   = 3'd4
  } mult_state_t;

  localparam int MULT_ITERS = 32;

endpackage

// File: rtl/mult_seq_adder.sv
// 32-bit ripple-carry adder with no carry-in and no carry-out; the multiply
// unit reconstructs the carry from the operand and sum MSBs when needed.
module mult_seq_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_sum
);

  logic w_carry;

  // Bit-serial carry chain, LSB first.
  always_comb begin
    w_carry = 1'b0;
    o_sum   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      o_sum[i] = i_a[i] ^ i_b[i] ^ w_carry;
      w_carry  = (i_a[i] & i_b[i]) | (w_carry & (i_a[i] ^ i_b[i]));
    end
  end

endmodule

// File: rtl/mult_seq.sv
// Multicycle MIPS MULT/MULTU: shift-and-add over one shared ripple adder,
// followed by an optional two-cycle 64-bit negation for signed results.
module mult_seq
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic             cancel,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mult_state_t      r_state;
  mult_state_t      w_next;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_mcand;
  logic [CNT_W-1:0] r_cnt;
  logic             r_neg;
  logic             r_carry_q;

  logic [WIDTH-1:0] w_add_a;
  logic [WIDTH-1:0] w_add_b;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;

  assign w_accept = start & ~cancel & ((r_state == IDLE) | (r_state == DONE));
  assign w_last   = (r_cnt == CNT_W'(MULT_ITERS - 1));
  assign w_abs_a  = op_a[WIDTH-1] ? (~op_a + WIDTH'(1)) : op_a;
  assign w_abs_b  = op_b[WIDTH-1] ? (~op_b + WIDTH'(1)) : op_b;
  // The adder drops its carry; recover it from the MSBs of inputs and sum.
  assign w_cout   = (w_add_a[WIDTH-1] & w_add_b[WIDTH-1]) |
                    ((w_add_a[WIDTH-1] ^ w_add_b[WIDTH-1]) & ~w_sum[WIDTH-1]);
  assign hi       = r_hi;
  assign lo       = r_lo;

  mult_seq_adder #(.WIDTH(WIDTH)) u_adder (
    .i_a   (w_add_a),
    .i_b   (w_add_b),
    .o_sum (w_sum)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; cancel overrides everything else.
  always_comb begin
    w_next = r_state;
    if (cancel) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_next = start ? RUN : IDLE;
        RUN:     w_next = w_last ? (r_neg ? NEG_LO : DONE) : RUN;
        NEG_LO:  w_next = NEG_HI;
        NEG_HI:  w_next = DONE;
        DONE:    w_next = start ? RUN : IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  // Status outputs decoded from state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      RUN, NEG_LO, NEG_HI: busy = 1'b1;
      DONE:                done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Adder operand mux; held at zero when idle to limit toggling.
  always_comb begin
    w_add_a = '0;
    w_add_b = '0;
    case (r_state)
      RUN: begin
        w_add_a = r_hi;
        w_add_b = r_lo[0] ? r_mcand : '0;
      end
      NEG_LO: begin
        w_add_a = ~r_lo;
        w_add_b = WIDTH'(1);
      end
      NEG_HI: begin
        w_add_a = ~r_hi;
        w_add_b = {{(WIDTH-1){1'b0}}, r_carry_q};
      end
      default: begin
        w_add_a = '0;
        w_add_b = '0;
      end
    endcase
  end

  // Datapath: operand capture, shift-and-add, and two-word negation.
  always_ff @(posedge clk) begin
    if (!rst_n || cancel) begin
      r_hi      <= '0;
      r_lo      <= '0;
      r_mcand   <= '0;
      r_cnt     <= '0;
      r_neg     <= 1'b0;
      r_carry_q <= 1'b0;
    end else if (w_accept) begin
      r_mcand   <= is_signed ? w_abs_a : op_a;
      r_lo      <= is_signed ? w_abs_b : op_b;
      r_hi      <= '0;
      r_cnt     <= '0;
      r_neg     <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
      r_carry_q <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          r_hi  <= {w_cout, w_sum[WIDTH-1:1]};
          r_lo  <= {w_sum[0], r_lo[WIDTH-1:1]};
          r_cnt <= r_cnt + CNT_W'(1);
        end
        NEG_LO: begin
          r_lo      <= w_sum;
          r_carry_q <= (r_lo == '0);
        end
        NEG_HI: begin
          r_hi <= w_sum;
        end
        default: begin
          r_hi <= r_hi;
          r_lo <= r_lo;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq: directed vector table, multi-cycle corner
// sequences, and random operands against a 64-bit arithmetic reference.
module tb_mult_seq;

  logic        clk = 1'b0;
  logic        rst_n, start, is_signed, cancel;
  logic [31:0] op_a, op_b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  mult_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
    .cancel(cancel), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] e_hi;
    logic [31:0] e_lo;
    int          e_lat;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Waits (bounded) for done; leaves time at the negedge of the done cycle.
  task automatic wait_done(output int lat, output bit busy_bad);
    lat = -1;
    busy_bad = 1'b0;
    while (cyc <= 45) begin
      @(negedge clk);
      if (done) begin
        lat = cyc;
        return;
      end
      if (!busy) busy_bad = 1'b1;
      step();
    end
  endtask

  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
    op_a = a; op_b = b; is_signed = s; start = 1'b1;
    cyc = 0;
    step();
    start = 1'b0;
  endtask

  // Full operation: latency, busy window, result, single-cycle done.
  task automatic run_check(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic s, input logic [31:0] e_hi, input logic [31:0] e_lo,
                           input int e_lat);
    int lat;
    bit busy_bad;
    launch(a, b, s);
    wait_done(lat, busy_bad);
    chk({name, " latency"}, 64'(lat), 64'(e_lat));
    chk({name, " busy"}, {63'd0, busy_bad}, 64'd0);
    chk({name, " result"}, {hi, lo}, {e_hi, e_lo});
    step();
    @(negedge clk);
    chk({name, " done_once"}, {62'd0, done, busy}, 64'd0);
    step();
  endtask

  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                           input logic s);
    longint pa, pb;
    if (s) begin
      pa = longint'($signed(a));
      pb = longint'($signed(b));
      return 64'(pa * pb);
    end else begin
      return {32'd0, a} * {32'd0, b};
    end
  endfunction

  initial begin
    int lat;
    bit busy_bad;
    bit seen;
    logic [31:0] ra, rb;
    logic        rs;
    logic [63:0] p;

    vecs[0] = '{32'd7,          32'd6,          1'b0, 32'h0000_0000, 32'h0000_002A, 33};
    vecs[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 32'hFFFF_FFFE, 32'h0000_0001, 33};
    vecs[2] = '{32'hFFFF_FFFD,  32'd5,          1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 35};
    vecs[3] = '{32'h8000_0000,  32'h8000_0000,  1'b1, 32'h4000_0000, 32'h0000_0000, 33};
    vecs[4] = '{32'h8000_0000,  32'd1,          1'b1, 32'hFFFF_FFFF, 32'h8000_0000, 35};
    vecs[5] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1, 32'h0000_0000, 32'h0000_0001, 33};
    vecs[6] = '{32'h0000_0000,  32'h1234_5678,  1'b0, 32'h0000_0000, 32'h0000_0000, 33};

    rst_n = 1'b0; start = 1'b0; cancel = 1'b0; is_signed = 1'b0;
    op_a = 32'd0; op_b = 32'd0;
    step(); step();
    @(negedge clk);
    chk("reset_state", {busy, done, hi, lo}, 66'd0);
    rst_n = 1'b1;
    step();

    foreach (vecs[i])
      run_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s,
                vecs[i].e_hi, vecs[i].e_lo, vecs[i].e_lat);

    // Start while busy must be ignored.
    launch(32'd7, 32'd6, 1'b0);
    while (cyc < 10) step();
    op_a = 32'd99; op_b = 32'd77; is_signed = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(lat, busy_bad);
    chk("ignored_start latency", 64'(lat), 64'd33);
    chk("ignored_start result", {hi, lo}, {32'd0, 32'h2A});
    step(); step();

    // Cancel mid-operation.
    launch(32'd7, 32'd6, 1'b0);
    while (cyc < 10) step();
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    @(negedge clk);
    chk("cancel state", {busy, done, hi, lo}, 66'd0);
    seen = 1'b0;
    repeat (40) begin
      step();
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("cancel no_done", {63'd0, seen}, 64'd0);

    // Cancel and start together in DONE: cancel wins.
    launch(32'd3, 32'd4, 1'b0);
    wait_done(lat, busy_bad);
    chk("cprio first", {hi, lo}, {32'd0, 32'd12});
    cancel = 1'b1; start = 1'b1; op_a = 32'd5; op_b = 32'd5;
    step();
    cancel = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("cprio state", {busy, done, hi, lo}, 66'd0);
    seen = 1'b0;
    repeat (40) begin
      step();
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    chk("cprio no_start", {63'd0, seen}, 64'd0);

    // Reset mid-operation.
    launch(32'hDEAD_BEEF, 32'h1234_5678, 1'b0);
    while (cyc < 20) step();
    rst_n = 1'b0;
    step();
    @(negedge clk);
    chk("reset_mid", {busy, done, hi, lo}, 66'd0);
    rst_n = 1'b1;
    step();

    // Back-to-back: start accepted during the DONE cycle.
    launch(32'd9, 32'd9, 1'b0);
    wait_done(lat, busy_bad);
    chk("b2b first", {hi, lo}, {32'd0, 32'd81});
    op_a = 32'd2; op_b = 32'd3; is_signed = 1'b0; start = 1'b1;
    cyc = 0;
    step();
    start = 1'b0;
    wait_done(lat, busy_bad);
    chk("b2b latency", 64'(lat), 64'd33);
    chk("b2b result", {hi, lo}, {32'd0, 32'd6});
    step(); step();

    // Random operands against the arithmetic reference.
    for (int k = 0; k < 24; k++) begin
      ra = $urandom();
      rb = $urandom();
      rs = 1'($urandom_range(1, 0));
      if (k == 0) ra = 32'h8000_0000;
      if (k == 1) rb = 32'd0;
      p = ref_prod(ra, rb, rs);
      run_check($sformatf("rand%0d", k), ra, rb, rs, p[63:32], p[31:0],
                (rs && (ra[31] ^ rb[31])) ? 35 : 33);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mult_seq.md
Name: mult_seq

Overview:
- Multicycle MIPS MULT/MULTU unit that owns and sequences one instance of the team's 32-bit ripple adder.
- Performs shift-and-add, one iteration per clock, with optional sign correction.
- Drives the HI/LO result pair consumed by MFHI/MFLO.
- Sits beside the ALU in EX; the pipeline stalls while busy=1.

Parameters:
- WIDTH, 32, operand width; the iteration count equals WIDTH; only 32 is supported.
- CNT_W, 5, iteration counter width, equal to log2(WIDTH).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  request; sampled only in IDLE or DONE
- is_signed  in  1  1 = MULT, 0 = MULTU; captured with start
- cancel  in  1  exception flush; aborts the operation
- op_a  in  32  multiplicand (rs); captured with start
- op_b  in  32  multiplier (rt); captured with start
- busy  out  1  high in RUN, NEG_LO and NEG_HI
- done  out  1  one-cycle completion pulse
- hi  out  32  upper product word
- lo  out  32  lower product word

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state goes to IDLE; hi=0, lo=0, busy=0, done=0, counter=0, neg flag=0.
  - Reset overrides every other input, including mid-operation.
- States: IDLE, RUN, NEG_LO, NEG_HI, DONE. busy and done are decoded from state.
- Start (accepted in IDLE or DONE when start=1 and cancel=0):
  - mcand <= |op_a| if is_signed, else op_a.
  - lo <= |op_b| if is_signed, else op_b.
  - hi <= 0, cnt <= 0.
  - neg <= is_signed & (op_a[31] ^ op_b[31]).
  - state <= RUN.
  - Absolute value is ~x+1 through a local incrementer. |0x80000000| = 0x80000000, which is correct when treated as unsigned.
- start while busy=1 is ignored and has no effect.
- RUN, each cycle:
  - Adder inputs are (hi, mcand) when lo[0]=1, else (hi, 0).
  - cout = (a[31]&b[31]) | ((a[31]^b[31]) & ~sum[31]); the adder has no carry output.
  - {hi,lo} <= {cout, sum, lo} >> 1.
  - cnt <= cnt+1.
  - On the iteration where cnt=31: state goes to NEG_LO if neg, else DONE.
- NEG_LO:
  - Adder computes ~lo + 1; lo <= sum.
  - carry_q <= (lo == 0), i.e. the carry out of the +1.
  - state <= NEG_HI.
- NEG_HI:
  - Adder computes ~hi + {31'b0, carry_q}; hi <= sum.
  - state <= DONE.
- DONE:
  - done=1 for exactly one cycle; hi/lo hold the result.
  - Next state is RUN if start is accepted, else IDLE.
- IDLE: hi/lo hold the last result indefinitely.
- Latency, counted from the start-sample cycle (cycle 0):
  - done is high in cycle 33 for unsigned results or non-negative signed results.
  - done is high in cycle 35 for negative signed results.
- cancel=1 in any state:
  - state <= IDLE next edge; hi=0, lo=0; no done pulse.
  - cancel takes priority over start in the same cycle.
- Adder sharing:
  - The adder instance is used only by this block.
  - Its inputs are muxed by state: RUN, NEG_LO or NEG_HI.
  - Inputs are driven to 0 in IDLE/DONE to limit toggling.
- All arithmetic is modulo 2^32 per word; the 64-bit product is exact for both signed and unsigned operation.

Decomposition:
- Shared package cpu_pkg:
  - state enum mult_state_t {IDLE, RUN, NEG_LO, NEG_HI, DONE}.
  - constant MULT_ITERS = 32.
- Sub-module: the existing 32-bit ripple adder, instantiated once. No other sub-modules.
- The FSM, counter, HI/LO registers and abs/carry logic stay in mult_seq.

Test Plan:
- Unsigned small: op_a=7, op_b=6, is_signed=0, start at cycle 0 -> busy=1 in cycles 1–32; done=1 in cycle 33 only; hi=0x00000000, lo=0x0000002A.
- Unsigned max: 0xFFFFFFFF × 0xFFFFFFFF, is_signed=0 -> hi=0xFFFFFFFE, lo=0x00000001 at cycle 33 (exercises cout on every iteration).
- Signed negative: op_a=0xFFFFFFFD (−3), op_b=5, is_signed=1 -> done in cycle 35; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- Signed corner: 0x80000000 × 0x80000000, is_signed=1 -> done in cycle 33 (neg=0); hi=0x40000000, lo=0.
- Signed corner: 0x80000000 × 1, is_signed=1 -> hi=0xFFFFFFFF, lo=0x80000000 in cycle 35.
- Ignored start: start=1 with new operands at cycle 10 during busy -> no effect; original 7×6 result and done timing are unchanged.
- Cancel: cancel at cycle 10 -> IDLE at cycle 11 with hi=lo=0 and no done pulse.
- Cancel priority: cancel and start asserted together in DONE -> goes to IDLE; the start is not accepted.
- Reset mid-operation: rst_n=0 at cycle 20 of an operation -> next edge gives IDLE, hi=lo=0, busy=0, done=0.
- Back-to-back: start asserted during the DONE cycle -> accepted; second result 2×3 gives lo=6 exactly 33 cycles later.
